// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// regfile_pkg : shared constants and helpers for the parametrised register file
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int NREGS_DEF  = 4;
   localparam int SP_IDX_DEF = 2;
   localparam int RA_IDX_DEF = 3;

   localparam logic [DATA_W_DEF-1:0] SP_ALL_ONES = {DATA_W_DEF{1'b1}};

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1)
         r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sp_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_sp_ctrl : stack-pointer next-value priority and saturation logic
// Revision        : 1.0
// ============================================================================
module regfile_sp_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] sp_cur,
   input  logic              wr_hit,
   input  logic [DATA_W-1:0] write_data,
   input  logic              push,
   input  logic              pop,
   output logic [DATA_W-1:0] sp_next,
   output logic              fault_set
);

   localparam logic [DATA_W-1:0] c_sp_max = {DATA_W{1'b1}};

   // A direct write wins; simultaneous push and pop cancel; the SP saturates.
   always_comb begin
      sp_next   = sp_cur;
      fault_set = 1'b0;
      if (wr_hit) begin
         sp_next = write_data;
      end else if (push && pop) begin
         sp_next = sp_cur;
      end else if (push) begin
         if (sp_cur == '0)
            fault_set = 1'b1;
         else
            sp_next = sp_cur - 1'b1;
      end else if (pop) begin
         if (sp_cur == c_sp_max)
            fault_set = 1'b1;
         else
            sp_next = sp_cur + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// regfile_param : NREGS x DATA_W register file, 2R/1W with write bypass,
//                 saturating stack pointer and registered compare flags
// Revision      : 1.0
// ============================================================================
module regfile_param
   import regfile_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                NREGS    = NREGS_DEF,
   parameter int                SP_IDX   = SP_IDX_DEF,
   parameter int                RA_IDX   = RA_IDX_DEF,
   parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
   localparam int               AW       = clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_write,
   input  logic [AW-1:0]     write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [AW-1:0]     read_addr1,
   input  logic [AW-1:0]     read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              sp_push,
   input  logic              sp_pop,
   output logic [DATA_W-1:0] sp_value,
   output logic              sp_fault,
   input  logic              comp_load0,
   input  logic              comp_load1,
   output logic              comp_eq,
   output logic              comp_lt
);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_comp0;
   logic [DATA_W-1:0] r_comp1;
   logic              r_sp_fault;
   logic              r_comp_eq;
   logic              r_comp_lt;

   logic              w_sp_wr_hit;
   logic [DATA_W-1:0] w_sp_next;
   logic              w_fault_set;
   logic [DATA_W-1:0] w_comp0_next;
   logic [DATA_W-1:0] w_comp1_next;

   function automatic logic [DATA_W-1:0] reset_value(input int idx);
      if (idx == SP_IDX)
         return SP_RESET;
      if (idx == RA_IDX)
         return '0;   // return address starts at the reset vector
      return '0;
   endfunction

   assign w_sp_wr_hit = reg_write && (write_addr == AW'(SP_IDX));

   regfile_sp_ctrl #(
      .DATA_W     (DATA_W)
   ) u_sp_ctrl (
      .sp_cur     (r_regs[SP_IDX]),
      .wr_hit     (w_sp_wr_hit),
      .write_data (write_data),
      .push       (sp_push),
      .pop        (sp_pop),
      .sp_next    (w_sp_next),
      .fault_set  (w_fault_set)
   );

   assign w_comp0_next = comp_load0 ? write_data : r_comp0;
   assign w_comp1_next = comp_load1 ? write_data : r_comp1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= reset_value(i);
         r_comp0    <= '0;
         r_comp1    <= '0;
         r_sp_fault <= 1'b0;
         r_comp_eq  <= 1'b1;
         r_comp_lt  <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i == SP_IDX)
               r_regs[i] <= w_sp_next;
            else if (reg_write && (write_addr == AW'(i)))
               r_regs[i] <= write_data;
         end
         r_comp0    <= w_comp0_next;
         r_comp1    <= w_comp1_next;
         r_sp_fault <= r_sp_fault | w_fault_set;
         // Flags track the values the compare registers are about to hold.
         r_comp_eq  <= (w_comp0_next == w_comp1_next);
         r_comp_lt  <= (w_comp0_next <  w_comp1_next);
      end
   end

   assign read_data1 = (reg_write && (write_addr == read_addr1)) ? write_data : r_regs[read_addr1];
   assign read_data2 = (reg_write && (write_addr == read_addr2)) ? write_data : r_regs[read_addr2];

   assign sp_value = r_regs[SP_IDX];
   assign sp_fault = r_sp_fault;
   assign comp_eq  = r_comp_eq;
   assign comp_lt  = r_comp_lt;

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised, clocked successor to the 4-entry 8-bit register file of the datapath.
- Holds NREGS general registers, one of which is the stack pointer. Provides two combinational read ports with write-through bypass and one synchronous write port.
- Adds stack-pointer push/pop with a sticky fault flag, plus two compare registers (comp0/comp1) with registered equal/less-than flags.
- Sits between the decoder/control unit and the ALU.

Parameters:
- DATA_W, 8, register width in bits.
- NREGS, 4, number of general registers; power of two, at least 4.
- SP_IDX, 2, index of the stack-pointer register.
- RA_IDX, 3, index of the return-address register; only reset-valued, otherwise an ordinary register.
- SP_RESET, {DATA_W{1'b1}}, reset value of the SP register; all-ones gives a descending stack from the top.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- reg_write  in  1  write enable for the general register file.
- write_addr  in  AW  destination index, where AW = clog2(NREGS).
- write_data  in  DATA_W  data for register and compare-register writes.
- read_addr1  in  AW  read port 1 index.
- read_addr2  in  AW  read port 2 index.
- read_data1  out  DATA_W  read port 1 data, combinational.
- read_data2  out  DATA_W  read port 2 data, combinational.
- sp_push  in  1  decrement SP by 1 at the clock edge.
- sp_pop  in  1  increment SP by 1 at the clock edge.
- sp_value  out  DATA_W  current SP contents, registered.
- sp_fault  out  1  sticky flag: SP overflow or underflow has been attempted.
- comp_load0  in  1  load comp0 from write_data.
- comp_load1  in  1  load comp1 from write_data.
- comp_eq  out  1  registered: comp0 == comp1.
- comp_lt  out  1  registered: comp0 < comp1, unsigned.

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - all registers go to 0, except register SP_IDX, which goes to SP_RESET;
  - comp0 and comp1 go to 0;
  - sp_fault goes to 0;
  - comp_eq goes to 1 and comp_lt goes to 0, consistent with 0 == 0;
  - reset overrides every other input in that cycle.
- Read ports:
  - zero latency: read_dataN = reg[read_addrN];
  - bypass: if reg_write = 1 and write_addr == read_addrN, read_dataN = write_data in the same cycle.
- Write:
  - with reg_write = 1, reg[write_addr] takes write_data at the edge;
  - the new value is visible unbypassed from the next cycle.
- SP update, evaluated in priority order per edge:
  1. reg_write to SP_IDX: SP takes write_data; push/pop are ignored; sp_fault is unchanged.
  2. sp_push and sp_pop both 1: SP is unchanged and no fault is raised.
  3. sp_push only:
     - SP == 0: SP holds at 0 and sp_fault is set;
     - otherwise SP becomes SP-1.
  4. sp_pop only:
     - SP == all-ones: SP holds and sp_fault is set;
     - otherwise SP becomes SP+1.
  - SP never wraps around.
- sp_fault stays set until reset.
- sp_value is the SP register output itself.
- SP bypass onto the read ports applies only to reg_write, not to push/pop. A push/pop result is visible on the read ports from the next cycle.
- Compare registers:
  - comp_load0 / comp_load1 load write_data independently; both may load in the same cycle;
  - both loads are independent of reg_write.
- Compare flags:
  - comp_eq and comp_lt are registered from the next-state values of comp0/comp1;
  - they are therefore valid in the cycle after a load, one-cycle latency relative to the load edge.
- Out-of-range read/write addresses cannot occur, because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - function clog2;
  - default index constants SP_IDX_DEF = 2 and RA_IDX_DEF = 3;
  - localparam SP_ALL_ONES derived from DATA_W.
- One sub-module, regfile_sp_ctrl:
  - inputs: SP current value, reg_write hit, write_data, push, pop;
  - outputs: SP next value, fault set;
  - purely the priority/saturation logic, instantiated once.
- The register array, bypass and compare logic stay in the top module.

Test Plan:
- Reset, then read all addresses: read_data = 0 for indices 0, 1, 3; read_data = 8'hFF for index 2; comp_eq = 1, comp_lt = 0, sp_fault = 0.
- Write 8'hA5 to reg 1 with read_addr1 = 1 in the same cycle: read_data1 = 8'hA5 in that cycle via bypass, and still 8'hA5 the next cycle with reg_write = 0.
- Write SP = 8'h01, then push twice: SP reads 8'h00 after the first push; after the second push SP holds 8'h00 and sp_fault = 1, which stays set after a subsequent pop (SP then becomes 8'h01).
- With SP = 8'hFF, pop: SP holds 8'hFF and sp_fault = 1. In a separate run with SP = 8'h10, push + pop together leaves SP at 8'h10; reg_write SP = 8'h40 together with push gives SP = 8'h40.
- comp_load0 with 8'h03, then comp_load1 with 8'h07 on the next cycle: one cycle after the second load comp_lt = 1, comp_eq = 0. Loading both with 8'h07 in one cycle gives comp_eq = 1, comp_lt = 0 on the next cycle.
- Assert rst_n = 0 in the same cycle as reg_write, push and comp_load0: all state returns to reset values and none of the requested updates take effect.
